// File: rtl/rv32_mem_port_arbiter_pkg.sv
// Shared types for the RV32 memory-port arbiter: FSM state encoding and the
// request payload carried on the data and memory ports.
package rv32_types;

    localparam int unsigned RV32_ADDR_W = 32;
    localparam int unsigned RV32_DATA_W = 32;
    localparam int unsigned RV32_BE_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_FETCH_WAIT = 2'd1,
        ARB_DATA_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [RV32_BE_W-1:0]   be;
        logic [RV32_ADDR_W-1:0] addr;
        logic [RV32_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rv32_mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and the
// load/store path (D) with one outstanding transaction at a time.
// D has priority. Grants and response routing are combinational.
// Optional build macro RV32_ARB_FAIR_EN: after STARVE_LIMIT consecutive D
// grants while IF waits, IF wins the next contested grant.
module rv32_mem_port_arbiter
    import rv32_types::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [RV32_DATA_W-1:0] if_rdata,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [RV32_BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [RV32_DATA_W-1:0] d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [RV32_DATA_W-1:0] d_rdata,

    output logic                   mem_req,
    output logic                   mem_we,
    output logic [RV32_BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [RV32_DATA_W-1:0] mem_wdata,
    input  logic                   mem_rvalid,
    input  logic [RV32_DATA_W-1:0] mem_rdata,

    output logic                   data_busy
);

    // A zero limit would let IF pre-empt D unconditionally; reject it at build time.
    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("rv32_mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant_ok;
    logic       force_if;
    mem_req_t   d_fields;
    mem_req_t   if_fields;
    mem_req_t   mem_fields;

`ifdef RV32_ARB_FAIR_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Counts D wins while IF is waiting; any IF grant or IF withdrawal resets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_if = if_req & d_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign force_if = 1'b0;
`endif

    // State register; a reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection and next state; a WAIT state can only re-issue on the response cycle.
    always_comb begin
        grant_ok  = 1'b0;
        d_gnt     = 1'b0;
        if_gnt    = 1'b0;
        state_nxt = state;

        grant_ok = ~rst & ((state == ARB_IDLE) | mem_rvalid);

        if (grant_ok) begin
            if (d_req && !force_if) begin
                d_gnt     = 1'b1;
                state_nxt = ARB_DATA_WAIT;
            end else if (if_req) begin
                if_gnt    = 1'b1;
                state_nxt = ARB_FETCH_WAIT;
            end else begin
                state_nxt = ARB_IDLE;
            end
        end
    end

    // Memory-side request mux; fields are zeroed whenever nothing is granted.
    always_comb begin
        d_fields.we     = d_we;
        d_fields.be     = d_be;
        d_fields.addr   = RV32_ADDR_W'(d_addr);
        d_fields.wdata  = d_wdata;

        if_fields.we    = 1'b0;
        if_fields.be    = 4'hF;
        if_fields.addr  = RV32_ADDR_W'(if_addr);
        if_fields.wdata = '0;

        mem_fields = '0;
        if (d_gnt) begin
            mem_fields = d_fields;
        end else if (if_gnt) begin
            mem_fields = if_fields;
        end

        mem_req   = d_gnt | if_gnt;
        mem_we    = mem_fields.we;
        mem_be    = mem_fields.be;
        mem_addr  = ADDR_W'(mem_fields.addr);
        mem_wdata = mem_fields.wdata;
    end

    // Response routing by the owner recorded in state; responses in IDLE are dropped.
    always_comb begin
        if_rvalid = ~rst & mem_rvalid & (state == ARB_FETCH_WAIT);
        d_rvalid  = ~rst & mem_rvalid & (state == ARB_DATA_WAIT);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
        data_busy = ~rst & (state == ARB_DATA_WAIT) & ~mem_rvalid;
    end

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Directed bench for rv32_mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later, mid-cycle.
module tb_rv32_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        data_busy;

    int checks_total;
    int checks_passed;

    rv32_mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .data_busy  (data_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h40;
        next_cycle();
        next_cycle();
        #1;
        checks_total++;
        if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, data_busy} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, data_busy});
        else checks_passed++;
        checks_total++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) $display("FAIL reset_mem_fields: got addr %h be %b", mem_addr, mem_be);
        else checks_passed++;
        rst = 1'b0;
        #1;
        checks_total++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_be !== 4'hF || mem_we !== 1'b0) $display("FAIL first_fetch: gnt %b addr %h be %b we %b want 1 00000040 1111 0", if_gnt, mem_addr, mem_be, mem_we);
        else checks_passed++;
        next_cycle();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        checks_total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || d_rvalid !== 1'b0) $display("FAIL first_fetch_resp: rvalid %b rdata %h d_rvalid %b", if_rvalid, if_rdata, d_rvalid);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF;
        #1;
        checks_total++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h100 || mem_we !== 1'b0) $display("FAIL simul_grant: d_gnt %b if_gnt %b addr %h we %b", d_gnt, if_gnt, mem_addr, mem_we);
        else checks_passed++;
        next_cycle();
        d_req = 1'b0;
        #1;
        checks_total++;
        if (data_busy !== 1'b1 || if_gnt !== 1'b0 || mem_req !== 1'b0) $display("FAIL simul_busy: busy %b if_gnt %b mem_req %b want 1 0 0", data_busy, if_gnt, mem_req);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks_total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || if_rvalid !== 1'b0 || if_rdata !== 32'h0 || data_busy !== 1'b0) $display("FAIL simul_resp: d_rvalid %b d_rdata %h if_rvalid %b busy %b", d_rvalid, d_rdata, if_rvalid, data_busy);
        else checks_passed++;
        checks_total++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h80) $display("FAIL simul_reissue: if_gnt %b addr %h want 1 00000080", if_gnt, mem_addr);
        else checks_passed++;
        next_cycle();
        if_req = 1'b0; mem_rdata = 32'h0000_0093;
        #1;
        checks_total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h93 || d_rvalid !== 1'b0) $display("FAIL simul_fetch_resp: if_rvalid %b rdata %h d_rvalid %b", if_rvalid, if_rdata, d_rvalid);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_back_to_back();
        int rv_seen;
        rv_seen = 0;
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(4 * i);
            mem_rvalid = (i > 0);
            mem_rdata = 32'h1000 + 32'(i);
            #1;
            if (if_rvalid === 1'b1) rv_seen++;
            checks_total++;
            if (if_gnt !== 1'b1 || mem_addr !== 32'(4 * i) || if_rvalid !== (i > 0)) $display("FAIL b2b_%0d: gnt %b addr %h rvalid %b", i, if_gnt, mem_addr, if_rvalid);
            else checks_passed++;
            next_cycle();
        end
        if_req = 1'b0; mem_rvalid = 1'b1;
        #1;
        if (if_rvalid === 1'b1) rv_seen++;
        checks_total++;
        if (if_gnt !== 1'b0 || rv_seen !== 3) $display("FAIL b2b_drain: if_gnt %b responses %0d want 0 3", if_gnt, rv_seen);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_store();
        #1;
        checks_total++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) $display("FAIL idle_fields: req %b addr %h wdata %h be %b", mem_req, mem_addr, mem_wdata, mem_be);
        else checks_passed++;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234;
        #1;
        checks_total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'h1234 || mem_addr !== 32'h200) $display("FAIL store_fields: req %b we %b be %b wdata %h addr %h", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        else checks_passed++;
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_wdata = '0;
        mem_rvalid = 1'b1; mem_rdata = '0;
        #1;
        checks_total++;
        if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) $display("FAIL store_ack: d_rvalid %b if_rvalid %b want 1 0", d_rvalid, if_rvalid);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_spurious();
        mem_rvalid = 1'b1; mem_rdata = 32'hAA;
        #1;
        checks_total++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL spurious_resp: if_rvalid %b d_rvalid %b", if_rvalid, d_rvalid);
        else checks_passed++;
        next_cycle();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h300;
        #1;
        checks_total++;
        if (if_gnt !== 1'b1 || data_busy !== 1'b0 || mem_addr !== 32'h300) $display("FAIL spurious_idle: if_gnt %b busy %b addr %h", if_gnt, data_busy, mem_addr);
        else checks_passed++;
        next_cycle();
        if_req = 1'b0; mem_rvalid = 1'b1;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_fairness();
        logic exp_if;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
        if_req = 1'b1; if_addr = 32'h500;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = (i > 0);
`ifdef RV32_ARB_FAIR_EN
            exp_if = (i == 4) || (i == 9);
`else
            exp_if = 1'b0;
`endif
            #1;
            checks_total++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) $display("FAIL fair_%0d: if_gnt %b d_gnt %b want if_gnt %b", i, if_gnt, d_gnt, exp_if);
            else checks_passed++;
            next_cycle();
        end
        d_req = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1;
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_addr = 32'h600;
        next_cycle();
        d_req = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h700;
        #1;
        checks_total++;
        if (data_busy !== 1'b0 || if_gnt !== 1'b1 || mem_addr !== 32'h700) $display("FAIL reset_mid: busy %b if_gnt %b addr %h want 0 1 00000700", data_busy, if_gnt, mem_addr);
        else checks_passed++;
        next_cycle();
        if_req = 1'b0; mem_rvalid = 1'b1;
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        checks_total = 0; checks_passed = 0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        test_reset();
        test_simultaneous();
        test_back_to_back();
        test_store();
        test_spurious();
        test_fairness();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
